// File: rtl/magphase_to_complex_pkg.sv
// magphase_to_complex_pkg: angle/gain constants and helpers for the polar-to-cartesian CORDIC.
package magphase_to_complex_pkg;
    localparam int PI_F13      = 25736;
    localparam int TWO_PI_F13  = 51472;
    localparam int HALF_PI_F13 = 12868;
    localparam int INV_K_Q15   = 19898;
    localparam int ATAN_FRAC   = 20;
    // atan(2^-i) with 20 fractional bits; requantised to the datapath angle format on use
    localparam int ATAN_TAB [18] = '{823550, 486170, 256879, 130396, 65451, 32757, 16383, 8192, 4096,
                                     2048, 1024, 512, 256, 128, 64, 32, 16, 8};

    function automatic int atan_q(input int i, input int frac);
        int sh;
        sh = ATAN_FRAC - frac;
        return sh > 0 ? (ATAN_TAB[i] + (1 << (sh - 1))) >>> sh : ATAN_TAB[i] <<< -sh;
    endfunction

    function automatic logic [15:0] sat16(input logic signed [31:0] v);
        return v > 32767 ? 16'h7fff : v < -32768 ? 16'h8000 : v[15:0];
    endfunction
endpackage

// File: rtl/cordic_rot_stage.sv
// cordic_rot_stage: one registered rotation-mode CORDIC micro-rotation with valid/tlast sideband.
module cordic_rot_stage #(
    parameter int SHIFT = 0,
    parameter int ATAN  = 0,
    parameter int W     = 22
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_ce,
    input  logic                i_valid,
    input  logic                i_last,
    input  logic signed [W-1:0] i_x,
    input  logic signed [W-1:0] i_y,
    input  logic signed [W-1:0] i_z,
    output logic                o_valid,
    output logic                o_last,
    output logic signed [W-1:0] o_x,
    output logic signed [W-1:0] o_y,
    output logic signed [W-1:0] o_z
);
    localparam logic signed [W-1:0] L_ATAN = W'(ATAN);
    logic w_pos;
    logic r_valid, r_last;
    logic signed [W-1:0] r_x, r_y, r_z;
    assign w_pos = ~i_z[W-1];
    always_ff @(posedge i_clk)
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (i_ce) begin
            r_valid <= i_valid;
            r_last  <= i_last;
        end
    always_ff @(posedge i_clk)
        if (i_ce) begin
            r_x <= w_pos ? i_x - (i_y >>> SHIFT) : i_x + (i_y >>> SHIFT);
            r_y <= w_pos ? i_y + (i_x >>> SHIFT) : i_y - (i_x >>> SHIFT);
            r_z <= w_pos ? i_z - L_ATAN : i_z + L_ATAN;
        end
    assign o_valid = r_valid;
    assign o_last  = r_last;
    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_z     = r_z;
endmodule

// File: rtl/magphase_to_complex.sv
// magphase_to_complex: pipelined polar (SP16 mag/phase) to cartesian (SC16 I/Q) CORDIC, one sample per clock.
module magphase_to_complex
    import magphase_to_complex_pkg::*;
#(
    parameter int ITERATIONS = 16,
    parameter int GUARD      = 3
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready
);
    // two bits above the 17+GUARD prescaled magnitude give headroom for CORDIC growth
    localparam int DW = 19 + GUARD;
    localparam logic signed [17:0]   L_PI      = 18'(PI_F13);
    localparam logic signed [17:0]   L_TWO_PI  = 18'(TWO_PI_F13);
    localparam logic signed [DW-1:0] L_HALF_PI = DW'(HALF_PI_F13 << GUARD);
    localparam logic signed [DW-1:0] L_RND     = DW'(1 << (GUARD - 1));
    logic w_ce, w_hi, w_lo;
    logic signed [17:0] w_ph, w_ph_wrap;
    logic signed [DW-1:0] w_mag, w_xr, w_yr, w_unused_z;
    logic r_v0, r_l0, r_v1, r_l1;
    logic signed [DW-1:0] r_m0, r_z0, r_x1, r_y1, r_z1;
    logic w_v [ITERATIONS+1];
    logic w_l [ITERATIONS+1];
    logic signed [DW-1:0] w_x [ITERATIONS+1];
    logic signed [DW-1:0] w_y [ITERATIONS+1];
    logic signed [DW-1:0] w_z [ITERATIONS+1];
    logic r_o_valid, r_o_last;
    logic [31:0] r_o_data;
    assign w_ce          = ~r_o_valid | m_axis_tready;
    assign s_axis_tready = w_ce & aresetn;
    assign w_ph      = {{2{s_axis_tdata[15]}}, s_axis_tdata[15:0]};
    assign w_ph_wrap = w_ph > L_PI ? w_ph - L_TWO_PI : w_ph < -L_PI ? w_ph + L_TWO_PI : w_ph;
    assign w_mag     = DW'((32'(s_axis_tdata[31:16]) * 32'(INV_K_Q15)) >> (15 - GUARD));
    assign w_hi      = r_z0 > L_HALF_PI;
    assign w_lo      = r_z0 < -L_HALF_PI;
    always_ff @(posedge aclk)
        if (!aresetn) begin
            r_v0 <= 1'b0;
            r_l0 <= 1'b0;
            r_v1 <= 1'b0;
            r_l1 <= 1'b0;
        end else if (w_ce) begin
            r_v0 <= s_axis_tvalid;
            r_l0 <= s_axis_tvalid & s_axis_tlast;
            r_v1 <= r_v0;
            r_l1 <= r_l0;
        end
    always_ff @(posedge aclk)
        if (w_ce) begin
            r_m0 <= w_mag;
            r_z0 <= DW'(w_ph_wrap) <<< GUARD;
            r_x1 <= (w_hi || w_lo) ? '0 : r_m0;
            r_y1 <= w_hi ? r_m0 : w_lo ? -r_m0 : '0;
            r_z1 <= w_hi ? r_z0 - L_HALF_PI : w_lo ? r_z0 + L_HALF_PI : r_z0;
        end
    assign w_v[0] = r_v1;
    assign w_l[0] = r_l1;
    assign w_x[0] = r_x1;
    assign w_y[0] = r_y1;
    assign w_z[0] = r_z1;
    for (genvar g = 0; g < ITERATIONS; g++) begin : g_rot
        cordic_rot_stage #(
            .SHIFT (g),
            .ATAN  (atan_q(g, 13 + GUARD)),
            .W     (DW)
        ) u_rot (
            .i_clk   (aclk),
            .i_rst_n (aresetn),
            .i_ce    (w_ce),
            .i_valid (w_v[g]),
            .i_last  (w_l[g]),
            .i_x     (w_x[g]),
            .i_y     (w_y[g]),
            .i_z     (w_z[g]),
            .o_valid (w_v[g+1]),
            .o_last  (w_l[g+1]),
            .o_x     (w_x[g+1]),
            .o_y     (w_y[g+1]),
            .o_z     (w_z[g+1])
        );
    end
    // residual angle after the last micro-rotation has no consumer
    assign w_unused_z = w_z[ITERATIONS];
    assign w_xr = (w_x[ITERATIONS] + L_RND) >>> GUARD;
    assign w_yr = (w_y[ITERATIONS] + L_RND) >>> GUARD;
    always_ff @(posedge aclk)
        if (!aresetn) begin
            r_o_valid <= 1'b0;
            r_o_last  <= 1'b0;
            r_o_data  <= '0;
        end else if (w_ce) begin
            r_o_valid <= w_v[ITERATIONS];
            r_o_last  <= w_l[ITERATIONS];
            r_o_data  <= {sat16(32'(w_xr)), sat16(32'(w_yr))};
        end
    assign m_axis_tvalid = r_o_valid;
    assign m_axis_tlast  = r_o_last;
    assign m_axis_tdata  = r_o_data;
endmodule
